// File: rtl/mem_request_arbiter.sv
// Arbiter that shares one memory port between instruction fetch and data access.
// It also steers store lanes, extends loads, and reports misalignment and timeouts.
module mem_request_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              imem_req,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              imem_done,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [31:0]       dmem_wdata,
    input  logic [1:0]        dmem_size,
    input  logic              dmem_unsigned,
    output logic [31:0]       dmem_rdata,
    output logic              dmem_done,
    output logic              err,
    output logic              stall,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_ben,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, IFETCH, DACCESS} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       imem_data_q;
    logic [31:0]       dmem_rdata_q;

    logic              data_req;
    logic              misaligned;
    logic              misalign_done;
    logic              active;
    logic              timeout;
    logic              complete;
    logic              start;
    logic [1:0]        off_q;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;

    assign data_req = dmem_ren | dmem_wen;
    assign active   = (state != IDLE);
    assign off_q    = addr_q[1:0];

    always_comb begin
        case (dmem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = dmem_addr[0];
            default: misaligned = (dmem_addr[1:0] != 2'b00);
        endcase
    end

    // Completions are suppressed while reset is held so an abandoned access never reports.
    assign misalign_done = nRST && (state == IDLE) && data_req && misaligned;
    assign timeout       = (TIMEOUT > 0) && active && !mem_ack && (cnt == CNT_LAST);
    assign complete      = nRST && active && (mem_ack || timeout);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (data_req && misaligned)
                    next_state = IDLE;
                else if (data_req && (D_PRIORITY || !imem_req))
                    next_state = DACCESS;
                else if (imem_req)
                    next_state = IFETCH;
            end
            IFETCH, DACCESS: begin
                if (mem_ack || timeout)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign start = (state == IDLE) && (next_state != IDLE);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= 32'h0;
            imem_data_q  <= 32'h0;
            dmem_rdata_q <= 32'h0;
        end else begin
            state <= next_state;
            if (start) begin
                cnt <= '0;
                if (next_state == DACCESS) begin
                    addr_q     <= dmem_addr;
                    size_q     <= dmem_size;
                    unsigned_q <= dmem_unsigned;
                    write_q    <= dmem_wen;
                    wdata_q    <= dmem_wdata;
                end else begin
                    addr_q     <= imem_addr;
                    size_q     <= 2'b10;
                    unsigned_q <= 1'b0;
                    write_q    <= 1'b0;
                    wdata_q    <= 32'h0;
                end
            end else if (active && !mem_ack) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (imem_done)
                imem_data_q <= imem_data;
            if (dmem_done)
                dmem_rdata_q <= dmem_rdata;
        end
    end

    assign mem_ren  = active && !write_q;
    assign mem_wen  = (state == DACCESS) && write_q;
    assign mem_addr = active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;

    always_comb begin
        mem_ben = 4'b0000;
        if (state == IFETCH) begin
            mem_ben = 4'b1111;
        end else if (state == DACCESS) begin
            case (size_q)
                2'b00:   mem_ben = 4'b0001 << off_q;
                2'b01:   mem_ben = off_q[1] ? 4'b1100 : 4'b0011;
                default: mem_ben = 4'b1111;
            endcase
        end
    end

    always_comb begin
        mem_wdata = 32'h0;
        if (mem_wen) begin
            case (size_q)
                2'b00:   mem_wdata = {4{wdata_q[7:0]}};
                2'b01:   mem_wdata = {2{wdata_q[15:0]}};
                default: mem_wdata = wdata_q;
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_val = unsigned_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = unsigned_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    assign imem_done = complete && (state == IFETCH);
    assign dmem_done = (complete && (state == DACCESS)) || misalign_done;
    assign err       = (complete && timeout) || misalign_done;

    // Aborted and misaligned completions return zero; stores return zero as well.
    assign imem_data  = imem_done ? (mem_ack ? mem_rdata : 32'h0) : imem_data_q;
    assign dmem_rdata = dmem_done ?
                        (((state == DACCESS) && mem_ack && !write_q) ? load_val : 32'h0) :
                        dmem_rdata_q;

    assign stall = ((state == IDLE) && (imem_req || data_req) && !misalign_done)
                || (active && !mem_ack && !timeout)
                || (imem_done && data_req)
                || (dmem_done && imem_req);

endmodule
